// File: rtl/fir_axil_ctrl.sv
// AXI-Lite control slave for the FIR core: ap_ctrl, data_length and the tap coefficient BRAM port.
// Latency: a write commits one cycle after awvalid&wvalid; read data is valid two cycles after arready.
// Backpressure: awready/wready/arready are one-cycle acks; rvalid/rdata are held until rready.
module fir_axil_ctrl #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int Tape_Num    = 11
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst_n,
    // write address / write data channels
    input  logic                   awvalid,
    input  logic [pADDR_WIDTH-1:0] awaddr,
    output logic                   awready,
    input  logic                   wvalid,
    input  logic [pDATA_WIDTH-1:0] wdata,
    output logic                   wready,
    // read address / read data channels
    input  logic                   arvalid,
    input  logic [pADDR_WIDTH-1:0] araddr,
    output logic                   arready,
    input  logic                   rready,
    output logic                   rvalid,
    output logic [pDATA_WIDTH-1:0] rdata,
    // tap coefficient BRAM port (1-cycle read latency)
    output logic [3:0]             tap_WE,
    output logic                   tap_EN,
    output logic [pDATA_WIDTH-1:0] tap_Di,
    output logic [pADDR_WIDTH-1:0] tap_A,
    input  logic [pDATA_WIDTH-1:0] tap_Do,
    // FIR datapath side
    input  logic [pADDR_WIDTH-1:0] core_tap_A,
    output logic [pDATA_WIDTH-1:0] core_tap_Do,
    input  logic                   core_done,
    output logic                   ap_start_o,
    output logic [pDATA_WIDTH-1:0] data_length_o
);

    localparam logic [pADDR_WIDTH-1:0] ADDR_CTRL    = '0;
    localparam logic [pADDR_WIDTH-1:0] ADDR_LEN     = pADDR_WIDTH'(16);
    localparam logic [pADDR_WIDTH-1:0] ADDR_TAP0    = pADDR_WIDTH'(32);
    localparam logic [pADDR_WIDTH-1:0] ADDR_TAP_END = pADDR_WIDTH'(32 + 4 * Tape_Num);

    localparam logic [0:0] W_IDLE  = 1'b0;
    localparam logic [0:0] W_ACK   = 1'b1;

    localparam logic [1:0] R_IDLE  = 2'd0;
    localparam logic [1:0] R_ADDR  = 2'd1;
    localparam logic [1:0] R_DATA  = 2'd2;
    localparam logic [1:0] R_VALID = 2'd3;

    // Read request captured while arready is high; tap_ok records whether
    // the BRAM was actually read on our behalf (controller owned the port).
    typedef struct packed {
        logic [pADDR_WIDTH-1:0] addr;
        logic                   tap_ok;
    } rd_meta_t;

    logic [0:0]             w_state;
    logic [1:0]             r_state;
    rd_meta_t               rd_meta;
    logic                   ap_idle;
    logic                   ap_done;
    logic                   wr_commit;
    logic                   wr_go;
    logic                   wr_is_tap;
    logic                   rd_is_tap;
    logic                   rd_tap_claim;
    logic [pDATA_WIDTH-1:0] rd_value;

    // Word-aligned address inside the tap coefficient window.
    function automatic logic is_tap(input logic [pADDR_WIDTH-1:0] a);
        return (a >= ADDR_TAP0) && (a < ADDR_TAP_END) && (a[1:0] == 2'b00);
    endfunction

    assign wr_is_tap = is_tap(awaddr);
    assign rd_is_tap = is_tap(araddr);

    // The BRAM has a single port. A tap read enters R_ADDR on the same edge a
    // tap write would enter W_ACK, so the write waits one cycle in that case;
    // a read cannot re-enter R_ADDR for several cycles, so the wait is bounded.
    assign rd_tap_claim = (r_state == R_IDLE) && arvalid && rd_is_tap;
    assign wr_go        = awvalid && wvalid && !(wr_is_tap && rd_tap_claim);

    assign wr_commit = (w_state == W_ACK);
    assign awready   = (w_state == W_ACK);
    assign wready    = (w_state == W_ACK);

    assign arready   = (r_state == R_ADDR);
    assign rvalid    = (r_state == R_VALID);

    assign core_tap_Do = tap_Do;

    // Write FSM: acknowledge both channels together for exactly one cycle.
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            w_state <= W_IDLE;
        end else begin
            case (w_state)
                W_IDLE:  if (wr_go) w_state <= W_ACK;
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Read FSM: address ack, one BRAM wait cycle, then hold data until rready.
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            r_state <= R_IDLE;
        end else begin
            case (r_state)
                R_IDLE:  if (arvalid) r_state <= R_ADDR;
                R_ADDR:  r_state <= R_DATA;
                R_DATA:  r_state <= R_VALID;
                default: if (rready) r_state <= R_IDLE;
            endcase
        end
    end

    // Latch the read address and port ownership at the end of R_ADDR.
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            rd_meta <= '0;
        end else if (r_state == R_ADDR) begin
            rd_meta.addr   <= araddr;
            rd_meta.tap_ok <= ap_idle;
        end
    end

    // Read-data mux; tap_Do is valid here because the BRAM was addressed in R_ADDR.
    always_comb begin
        rd_value = '0;
        if (rd_meta.addr == ADDR_CTRL) begin
            rd_value = {{(pDATA_WIDTH-3){1'b0}}, ap_idle, ap_done, ap_start_o};
        end else if (rd_meta.addr == ADDR_LEN) begin
            rd_value = data_length_o;
        end else if (is_tap(rd_meta.addr)) begin
            rd_value = rd_meta.tap_ok ? tap_Do : '1;
        end
    end

    // Capture read data during R_DATA; it stays stable through R_VALID.
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            rdata <= '0;
        end else if (r_state == R_DATA) begin
            rdata <= rd_value;
        end
    end

    // ap_ctrl: start only from idle; core_done sets done/idle and beats a read-clear.
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            ap_start_o <= 1'b0;
            ap_idle    <= 1'b1;
            ap_done    <= 1'b0;
        end else begin
            ap_start_o <= 1'b0;
            if (wr_commit && (awaddr == ADDR_CTRL) && wdata[0] && ap_idle) begin
                ap_start_o <= 1'b1;
                ap_idle    <= 1'b0;
            end
            if (core_done) begin
                ap_done <= 1'b1;
                ap_idle <= 1'b1;
            end else if ((r_state == R_VALID) && rready && (rd_meta.addr == ADDR_CTRL)) begin
                ap_done <= 1'b0;
            end
        end
    end

    // data_length is writable regardless of core state.
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            data_length_o <= '0;
        end else if (wr_commit && (awaddr == ADDR_LEN)) begin
            data_length_o <= wdata;
        end
    end

    // Tap port ownership: core while running, otherwise the AXI write or read in flight.
    always_comb begin
        tap_EN = 1'b0;
        tap_WE = 4'h0;
        tap_A  = '0;
        tap_Di = wdata;
        if (!ap_idle) begin
            tap_EN = 1'b1;
            tap_A  = core_tap_A;
        end else if (wr_commit && wr_is_tap) begin
            tap_EN = 1'b1;
            tap_WE = 4'hF;
            tap_A  = awaddr - ADDR_TAP0;
        end else if ((r_state == R_ADDR) && rd_is_tap) begin
            tap_EN = 1'b1;
            tap_A  = araddr - ADDR_TAP0;
        end
    end

endmodule
